// File: rtl/stdmacro_skid_pkg.sv
// stdmacro_skid_pkg
// Shared definitions for the two-entry skid buffer.
// The state encoding doubles as the occupancy count, so the count port is the
// state register itself with no extra decode.
package stdmacro_skid_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/stdmacro_skid_buffer_dfferan.sv
// std_dfferan
// Enable-controlled D flip-flop bank with asynchronous active-low reset to zero.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, clears q
//   en     - load enable; q holds when low
//   d      - data in  [WIDTH-1:0]
//   q      - data out [WIDTH-1:0]
module std_dfferan #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/stdmacro_skid_buffer.sv
// stdmacro_skid_buffer
// Two-entry registered pipeline slice. Upstream and downstream handshakes are
// decoupled: s_ready and m_valid come straight from the state flops, so no
// combinational path runs from one side to the other.
// Optional feature macro: STDMACRO_SKID_FLUSH_EN adds a synchronous flush input.
// Ports:
//   clk      - clock, rising edge
//   aresetn  - asynchronous active-low reset
//   s_valid  - upstream beat present
//   s_ready  - buffer can accept a beat (from state flops)
//   s_data   - upstream payload [DATA_WIDTH-1:0]
//   m_valid  - downstream beat present (from state flops)
//   m_ready  - downstream accepts beat
//   m_data   - downstream payload, driven by the main register
//   count    - occupancy 0..2
//   flush    - discard all entries (only with STDMACRO_SKID_FLUSH_EN)
//
// state      | meaning
// -----------+-------------------------------------------
// SKID_EMPTY | no entries; count 0
// SKID_BUSY  | main register valid; count 1
// SKID_FULL  | main and skid valid, skid is the younger; count 2
module stdmacro_skid_buffer
    import stdmacro_skid_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
`ifdef STDMACRO_SKID_FLUSH_EN
    input  logic                  flush,
`endif
    output logic [1:0]            count
);

    skid_state_e           state;
    logic                  in_beat;
    logic                  out_beat;
    logic                  kill;
    logic                  main_en;
    logic                  skid_en;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;

    assign s_ready  = (state != SKID_FULL);
    assign m_valid  = (state != SKID_EMPTY);
    assign count    = state;
    assign in_beat  = s_valid & s_ready;
    assign out_beat = m_valid & m_ready;

`ifdef STDMACRO_SKID_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    // Loads are suppressed on a flush so a dropped beat never reaches m_data.
    always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = s_data;
        case (state)
            SKID_EMPTY: main_en = in_beat;
            SKID_BUSY: begin
                main_en = in_beat & out_beat;
                skid_en = in_beat & ~out_beat;
            end
            SKID_FULL: begin
                main_en = out_beat;
                main_d  = skid_q;
            end
            default: ;
        endcase
        if (kill) begin
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= SKID_EMPTY;
        end else if (kill) begin
            state <= SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: if (in_beat) state <= SKID_BUSY;
                SKID_BUSY: begin
                    if (in_beat && !out_beat)      state <= SKID_FULL;
                    else if (!in_beat && out_beat) state <= SKID_EMPTY;
                end
                SKID_FULL: if (out_beat) state <= SKID_BUSY;
                default: state <= SKID_EMPTY;
            endcase
        end
    end

    std_dfferan #(.WIDTH(DATA_WIDTH)) u_main (
        .clk   (clk),
        .rst_n (aresetn),
        .en    (main_en),
        .d     (main_d),
        .q     (m_data)
    );

    std_dfferan #(.WIDTH(DATA_WIDTH)) u_skid (
        .clk   (clk),
        .rst_n (aresetn),
        .en    (skid_en),
        .d     (s_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_stdmacro_skid_buffer.sv
module tb_stdmacro_skid_buffer;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [1:0]  count;
`ifdef STDMACRO_SKID_FLUSH_EN
    logic        flush;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    stdmacro_skid_buffer #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
`ifdef STDMACRO_SKID_FLUSH_EN
        .flush   (flush),
`endif
        .count   (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // one rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic mv, input logic sr,
                           input logic [1:0] cnt, input logic [31:0] md);
        chk({tag, ".m_valid"}, {31'd0, m_valid}, {31'd0, mv});
        chk({tag, ".s_ready"}, {31'd0, s_ready}, {31'd0, sr});
        chk({tag, ".count"},   {30'd0, count},   {30'd0, cnt});
        chk({tag, ".m_data"},  m_data,           md);
    endtask

    initial begin
        aresetn = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hA5;
        m_ready = 1'b0;
`ifdef STDMACRO_SKID_FLUSH_EN
        flush   = 1'b0;
`endif
        // reset held across edges with s_valid high
        #2;
        chk_out("rst0", 1'b0, 1'b1, 2'd0, 32'h0);
        step();
        step();
        chk_out("rst1", 1'b0, 1'b1, 2'd0, 32'h0);
        aresetn = 1'b1;
        step();
        chk_out("first", 1'b1, 1'b1, 2'd1, 32'hA5);

        // drain; m_data holds last value
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        chk_out("drain", 1'b0, 1'b1, 2'd0, 32'hA5);

        // streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            step();
            chk_out($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 32'(i));
        end
        s_valid = 1'b0;
        step();
        chk_out("stream_end", 1'b0, 1'b1, 2'd0, 32'h8);

        // stall fill
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h11;
        step();
        chk_out("fill1", 1'b1, 1'b1, 2'd1, 32'h11);
        s_data = 32'h22;
        step();
        chk_out("fill2", 1'b1, 1'b0, 2'd2, 32'h11);
        s_data = 32'h99;   // offered while full, must be ignored
        step();
        chk_out("full_hold", 1'b1, 1'b0, 2'd2, 32'h11);
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        chk_out("unfill1", 1'b1, 1'b1, 2'd1, 32'h22);
        step();
        chk_out("unfill2", 1'b0, 1'b1, 2'd0, 32'h22);

        // simultaneous in & out in BUSY
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h33;
        step();
        chk_out("sim_a", 1'b1, 1'b1, 2'd1, 32'h33);
        s_data  = 32'h44;
        m_ready = 1'b1;
        step();
        chk_out("sim_b", 1'b1, 1'b1, 2'd1, 32'h44);
        s_valid = 1'b0;
        step();
        chk_out("sim_c", 1'b0, 1'b1, 2'd0, 32'h44);

        // async reset while FULL
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hAA;
        step();
        s_data = 32'hBB;
        step();
        chk_out("pre_arst", 1'b1, 1'b0, 2'd2, 32'hAA);
        s_valid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        chk_out("arst", 1'b0, 1'b1, 2'd0, 32'h0);
        #3;
        aresetn = 1'b1;
        step();
        chk_out("post_arst", 1'b0, 1'b1, 2'd0, 32'h0);
        // skid must be empty: two new beats drain in order
        s_valid = 1'b1;
        s_data  = 32'h01;
        step();
        s_data = 32'h02;
        step();
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk_out("order_a", 1'b1, 1'b0, 2'd2, 32'h01);
        step();
        chk_out("order_b", 1'b1, 1'b1, 2'd1, 32'h02);
        step();
        chk_out("order_c", 1'b0, 1'b1, 2'd0, 32'h02);

`ifdef STDMACRO_SKID_FLUSH_EN
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h61;
        step();
        s_data = 32'h62;
        step();
        chk_out("fl_full", 1'b1, 1'b0, 2'd2, 32'h61);
        s_valid = 1'b0;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        chk_out("fl_a", 1'b0, 1'b1, 2'd0, 32'h61);
        s_valid = 1'b1;
        s_data  = 32'h66;
        step();
        chk_out("fl_busy", 1'b1, 1'b1, 2'd1, 32'h66);
        s_data = 32'h55;
        flush  = 1'b1;
        step();
        flush   = 1'b0;
        s_valid = 1'b0;
        chk_out("fl_b", 1'b0, 1'b1, 2'd0, 32'h66);
        step();
        chk_out("fl_c", 1'b0, 1'b1, 2'd0, 32'h66);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
